// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer: parses loader words into sync/header/row data and sequences row writes and frame commits.
module config_frame_sequencer #(
  parameter int          NumberOfRows    = 16,
  parameter int          NumberOfCols    = 16,
  parameter int          MaxFramesPerCol = 20,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] WriteData,
  input  logic        WriteStrobe,
  input  logic        ComActive,
  output logic [31:0] RowData,
  output logic [4:0]  RowSelect,
  output logic        RowWriteStrobe,
  output logic        FrameStrobe,
  output logic [6:0]  FrameColumn,
  output logic [4:0]  FrameIndex,
  output logic        ConfigBusy,
  output logic        ErrorFlag
);
  typedef enum logic [1:0] {IDLE, HEADER, DATA, COMMIT} state_t;
  localparam logic [4:0] LAST = 5'(NumberOfRows - 1);
  state_t     state;
  logic [4:0] row;
  logic       skip;
  logic [6:0] col;
  logic [4:0] idx;
  logic       bad;
  assign bad = 32'(WriteData[30:24]) >= NumberOfCols || 32'(WriteData[4:0]) >= MaxFramesPerCol;
  // Header fields land in col/idx first; the outputs trail by one cycle so a
  // header taken in the COMMIT cycle cannot disturb the pending FrameStrobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      row            <= '0;
      skip           <= 1'b0;
      col            <= '0;
      idx            <= '0;
      RowData        <= '0;
      RowSelect      <= '0;
      RowWriteStrobe <= 1'b0;
      FrameStrobe    <= 1'b0;
      FrameColumn    <= '0;
      FrameIndex     <= '0;
      ConfigBusy     <= 1'b0;
      ErrorFlag      <= 1'b0;
    end else begin
      RowWriteStrobe <= 1'b0;
      FrameStrobe    <= 1'b0;
      FrameColumn    <= col;
      FrameIndex     <= idx;
      if (state != IDLE && !ComActive) begin
        state      <= IDLE;
        ConfigBusy <= 1'b0;
        skip       <= 1'b0;
        row        <= '0;
        if (state == DATA) ErrorFlag <= 1'b1;
        if (state == COMMIT) FrameStrobe <= !skip;
      end else begin
        case (state)
          IDLE: if (WriteStrobe && WriteData == SyncWord) begin
            state      <= HEADER;
            ConfigBusy <= 1'b1;
            ErrorFlag  <= 1'b0;
          end
          DATA: if (WriteStrobe) begin
            if (!skip) begin
              RowData        <= WriteData;
              RowSelect      <= row;
              RowWriteStrobe <= 1'b1;
            end
            row <= row + 5'd1;
            if (row == LAST) state <= COMMIT;
          end
          default: begin
            if (state == COMMIT) begin
              FrameStrobe <= !skip;
              skip        <= 1'b0;
              state       <= HEADER;
            end
            if (WriteStrobe) begin
              if (WriteData[31]) begin
                state      <= IDLE;
                ConfigBusy <= 1'b0;
              end else begin
                col   <= WriteData[30:24];
                idx   <= WriteData[4:0];
                row   <= '0;
                state <= DATA;
                if (bad) begin
                  skip      <= 1'b1;
                  ErrorFlag <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb_config_frame_sequencer: directed frames with hand-computed row/frame strobes, timing and error flag.
module tb_config_frame_sequencer;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  logic        clk = 1'b0, rst = 1'b1, ws = 1'b0, ca = 1'b1;
  logic [31:0] wd = '0;
  logic [31:0] row_data;
  logic [4:0]  row_select, frame_index;
  logic [6:0]  frame_column;
  logic        row_write_strobe, frame_strobe, config_busy, error_flag;
  int errors = 0, checks = 0, cyc = 0, put_cyc = 0, nrw = 0, nfs = 0, b = 0, f = 0, p1 = 0;
  logic [36:0] rw_log [64];
  logic [11:0] fs_log [16];
  int          fs_cyc [16];

  config_frame_sequencer #(.NumberOfRows(4)) dut (
    .CLK(clk), .RST(rst), .WriteData(wd), .WriteStrobe(ws), .ComActive(ca),
    .RowData(row_data), .RowSelect(row_select), .RowWriteStrobe(row_write_strobe),
    .FrameStrobe(frame_strobe), .FrameColumn(frame_column), .FrameIndex(frame_index),
    .ConfigBusy(config_busy), .ErrorFlag(error_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (row_write_strobe && nrw < 64) begin
      rw_log[nrw] = {row_select, row_data};
      nrw++;
    end
    if (frame_strobe && nfs < 16) begin
      fs_log[nfs] = {frame_column, frame_index};
      fs_cyc[nfs] = cyc;
      nfs++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] d);
    @(negedge clk);
    ws = 1'b1;
    wd = d;
    put_cyc = cyc;
  endtask

  task automatic put4(input logic [31:0] d0, d1, d2, d3);
    put(d0); put(d1); put(d2); put(d3);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      ws = 1'b0;
    end
  endtask

  task automatic chk_rows(input string tag, input int base, input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) chk(tag, 64'(rw_log[base + i]), 64'({5'(i), d[i]}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", config_busy, 0);
    chk("rst_err", error_flag, 0);
    chk("rst_rws", row_write_strobe, 0);
    rst = 1'b0;
    // nominal frame
    put(SYNC); put(32'h0300_0002);
    put4(32'h11, 32'h22, 32'h33, 32'h44);
    gap(4);
    chk("t1_nrw", nrw, 4);
    chk_rows("t1_row", 0, 32'h11, 32'h22, 32'h33, 32'h44);
    chk("t1_nfs", nfs, 1);
    chk("t1_colidx", fs_log[0], {7'd3, 5'd2});
    chk("t1_fs_time", fs_cyc[0], put_cyc + 2);
    chk("t1_err", error_flag, 0);
    chk("t1_busy", config_busy, 1);
    // back-to-back frames, second header in the COMMIT cycle
    b = nrw; f = nfs;
    put(32'h0500_0007);
    put4(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    p1 = put_cyc;
    put(32'h0601_0004);
    put4(32'hB1, 32'hB2, 32'hB3, 32'hB4);
    gap(4);
    chk("t2_nrw", nrw - b, 8);
    chk_rows("t2_rowa", b, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    chk_rows("t2_rowb", b + 4, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    chk("t2_nfs", nfs - f, 2);
    chk("t2_colidx1", fs_log[f], {7'd5, 5'd7});
    chk("t2_fs1_time", fs_cyc[f], p1 + 2);
    chk("t2_colidx2", fs_log[f + 1], {7'd6, 5'd4});
    // out-of-range column, then boundary-valid frame, then out-of-range index
    b = nrw; f = nfs;
    put(32'h1000_0001);
    put4(32'hC1, 32'hC2, 32'hC3, 32'hC4);
    gap(4);
    chk("t3_err", error_flag, 1);
    chk("t3_nrw", nrw - b, 0);
    chk("t3_nfs", nfs - f, 0);
    put(32'h0F00_0013);
    put4(32'hD1, 32'hD2, 32'hD3, 32'hD4);
    gap(4);
    chk("t3_nrw_ok", nrw - b, 4);
    chk_rows("t3_row", b, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
    chk("t3_nfs_ok", nfs - f, 1);
    chk("t3_colidx", fs_log[f], {7'd15, 5'd19});
    chk("t3_err_sticky", error_flag, 1);
    put(32'h0000_0014);
    put4(32'hD5, 32'hD6, 32'hD7, 32'hD8);
    gap(4);
    chk("t3_idx_nrw", nrw - b, 4);
    chk("t3_idx_nfs", nfs - f, 1);
    // desync, stray data ignored, new sync clears error
    b = nrw; f = nfs;
    put(32'h8000_0000);
    gap(2);
    chk("t4_busy", config_busy, 0);
    put4(32'h0300_0002, 32'h12, 32'h13, 32'h14);
    gap(3);
    chk("t4_nrw", nrw - b, 0);
    chk("t4_nfs", nfs - f, 0);
    chk("t4_err_sticky", error_flag, 1);
    put(SYNC);
    gap(2);
    chk("t4_err_clr", error_flag, 0);
    chk("t4_busy_sync", config_busy, 1);
    // ComActive drops mid-frame
    put(32'h0100_0001); put(32'hE1); put(32'hE2);
    @(negedge clk);
    ws = 1'b0;
    ca = 1'b0;
    @(negedge clk);
    chk("t5_busy", config_busy, 0);
    chk("t5_err", error_flag, 1);
    ca = 1'b1;
    gap(3);
    chk("t5_nrw", nrw - b, 2);
    chk("t5_nfs", nfs - f, 0);
    // asynchronous reset mid-frame
    put(SYNC); put(32'h0200_0001); put(32'hF1); put(32'hF2);
    @(negedge clk);
    ws = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", config_busy, 0);
    chk("t6_err", error_flag, 0);
    chk("t6_rowdata", row_data, 0);
    chk("t6_col", frame_column, 0);
    chk("t6_idx", frame_index, 0);
    #1 rst = 1'b0;
    b = nrw; f = nfs;
    put(SYNC); put(32'h0400_0005);
    put4(32'h31, 32'h32, 32'h33, 32'h34);
    gap(4);
    chk("t6_nrw", nrw - b, 4);
    chk_rows("t6_row", b, 32'h31, 32'h32, 32'h33, 32'h34);
    chk("t6_nfs", nfs - f, 1);
    chk("t6_colidx", fs_log[f], {7'd4, 5'd5});
    chk("t6_err_end", error_flag, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
